mac_operand_feeder: RTL and testbench
=====================================

MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning number of array rows and columns fed.
REQ-002 SHALL have parameter DEPTH, default 4, meaning operand vector length K per lane.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port wr_en, input, 1, operand buffer write strobe.
REQ-006 SHALL have port wr_sel, input, 1, buffer select: 0 = B (row) buffer, 1 = C (column) buffer.
REQ-007 SHALL have port wr_lane, input, clog2(LANES), target lane.
REQ-008 SHALL have port wr_idx, input, clog2(DEPTH), element index k within the lane.
REQ-009 SHALL have port wr_data, input, 8, FP8 operand.
REQ-010 SHALL have port start, input, 1, one-cycle request to begin a feed pass.
REQ-011 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at pass end.
REQ-013 SHALL have port b_out, output, 8*LANES, row operands; lane i occupies bits [8i+7:8i].
REQ-014 SHALL have port c_out, output, 8*LANES, column operands with the same packing.
REQ-015 SHALL have port arr_clr, output, 1, accumulator clear for the MAC array.

Function
REQ-016 SHALL hold two DEPTH x LANES byte buffers (B, C); a write with wr_en=1 and busy=0 stores wr_data at [wr_lane][wr_idx].
REQ-017 SHALL ignore writes while busy=1 and ignore start while busy=1.
REQ-018 SHALL implement states IDLE, CLEAR, STREAM, FLUSH, FIN.
REQ-019 SHALL go IDLE->CLEAR on start with busy=0; CLEAR lasts 1 cycle, arr_clr=1, b_out=c_out=0.
REQ-020 SHALL, in STREAM, run counter t = 0..DEPTH+LANES-2; lane i drives B[i][t-i] on b_out and C[i][t-i] on c_out when 0<=t-i<DEPTH, else 8'h00.
REQ-021 SHALL, in FLUSH, drive all lanes to 8'h00 for LANES-1 cycles, so the final operand pair reaches cell (LANES-1, LANES-1).
REQ-022 SHALL, in FIN, assert done for exactly one cycle, drop busy in the same cycle, and return to IDLE.
REQ-023 SHALL register b_out, c_out, and arr_clr, with no combinational path from inputs.
REQ-024 SHALL keep buffer contents after a pass, so start alone replays the same operands.
REQ-025 SHALL allow a start in the cycle immediately after FIN to be accepted.
REQ-026 SHALL treat 8'h00 as the bubble value; a zero stored operand streams as 8'h00 without special handling.

Reset
REQ-027 SHALL, on reset low, immediately force IDLE and t=0, with busy=0, done=0, arr_clr=0, b_out=0, c_out=0, and clear both buffers to 8'h00.
REQ-028 SHALL abort a pass when reset is asserted mid-pass, with no done pulse; operation resumes on the first clk edge after reset goes high.

Configuration
REQ-029 SHALL, with macro FEEDER_ARR_CLR_EN defined, include the CLEAR state and arr_clr behaviour defined in REQ-019.
REQ-030 SHALL, without FEEDER_ARR_CLR_EN, omit CLEAR (IDLE->STREAM on start) and tie arr_clr to 0; total pass length then shrinks by one cycle.

Verification
REQ-031 SHALL cover full pass, LANES=DEPTH=4, macro defined, B[i][k]=C[i][k]=8'h10+4i+k: start at cycle 0 -> arr_clr high cycle 1; STREAM cycles 2-8; FLUSH 9-11; done cycle 12; lane3 b_out=8'h1C at cycle 5, 8'h00 at cycle 4.
REQ-032 SHALL cover macro undefined, same data: done at cycle 11 and arr_clr never high.
REQ-033 SHALL cover write during busy: write 8'hFF to B[0][0] at cycle 3, then replay -> lane0 first operand is still 8'h10.
REQ-034 SHALL cover start during busy: pulse start at cycle 6 -> exactly one done pulse, and still at cycle 12.
REQ-035 SHALL cover reset mid-pass: reset low at cycle 7 -> all outputs 0 immediately, no done, and buffers read back 8'h00 on a following pass.
REQ-036 SHALL cover back-to-back passes: start in the cycle after done -> second pass produces an identical operand trace offset by 12 cycles.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: stages FP8 operand vectors for a LANES x LANES MAC array
// and streams them out skewed by one cycle per lane, so that row/column lane i
// starts i cycles after lane 0 and matching operands meet inside the array.
//
// Ports
//   clk      - clock, all state updates on the rising edge
//   reset    - asynchronous active-low reset (clears state and both buffers)
//   wr_en    - operand write strobe (ignored while busy)
//   wr_sel   - 0 = B (row) buffer, 1 = C (column) buffer
//   wr_lane  - target lane
//   wr_idx   - element index k within the lane
//   wr_data  - FP8 operand
//   start    - one-cycle request to begin a feed pass (ignored while busy)
//   busy     - pass in progress
//   done     - one-cycle pulse at pass end
//   b_out    - row operands, lane i at [8i+7:8i]
//   c_out    - column operands, same packing
//   arr_clr  - accumulator clear for the MAC array
//
// Build option: FEEDER_ARR_CLR_EN adds a one-cycle CLEAR state driving arr_clr
// before streaming; without it arr_clr is tied low and the pass is one cycle
// shorter.

// One lane: holds the B and C vectors and registers the operand for the next
// stream step. The lane's skew is the LANE parameter.
module feeder_lane #(
  parameter int LANE  = 0,
  parameter int DEPTH = 4,
  parameter int IW    = 2,
  parameter int TW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_b,
  input  logic          wr_c,
  input  logic [IW-1:0] wr_idx,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [TW-1:0] rd_t,
  output logic [7:0]    b_q,
  output logic [7:0]    c_q
);
  logic [DEPTH-1:0][7:0] b_mem, c_mem;
  logic                  hit;
  logic [IW-1:0]         ridx;
  int                    k;

  // Element k = t - LANE is live only inside [0, DEPTH); outside it the lane
  // emits the 8'h00 bubble.
  always_comb begin
    k    = int'(rd_t) - LANE;
    hit  = rd_en && (k >= 0) && (k < DEPTH);
    ridx = IW'(k);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_mem <= '0;
      c_mem <= '0;
      b_q   <= '0;
      c_q   <= '0;
    end else begin
      if (wr_b && int'(wr_idx) < DEPTH) b_mem[wr_idx] <= wr_data;
      if (wr_c && int'(wr_idx) < DEPTH) c_mem[wr_idx] <= wr_data;
      b_q <= hit ? b_mem[ridx] : 8'h00;
      c_q <= hit ? c_mem[ridx] : 8'h00;
    end
  end
endmodule

module mac_operand_feeder #(
  parameter  int LANES = 4,
  parameter  int DEPTH = 4,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [LW-1:0]      wr_lane,
  input  logic [IW-1:0]      wr_idx,
  input  logic [7:0]         wr_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [8*LANES-1:0] b_out,
  output logic [8*LANES-1:0] c_out,
  output logic               arr_clr
);
  localparam int TW     = $clog2(DEPTH + LANES);
  localparam int LAST_T = DEPTH + LANES - 2;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, FIN} state_t;

  state_t                  state, state_n;
  logic [TW-1:0]           t, t_n;
  logic                    wr_ok;
  logic [LANES-1:0][7:0]   b_q, c_q;

  assign busy  = (state == CLEAR) || (state == STREAM) || (state == FLUSH);
  assign done  = (state == FIN);
  assign wr_ok = wr_en && !busy;

  // FIN already has busy low, so a start there begins the next pass
  // without an idle gap.
  always_comb begin
    state_n = state;
    t_n     = t;
    case (state)
      IDLE, FIN: begin
        state_n = IDLE;
        if (start) begin
`ifdef FEEDER_ARR_CLR_EN
          state_n = CLEAR;
`else
          state_n = STREAM;
`endif
          t_n = '0;
        end
      end
      CLEAR: begin
        state_n = STREAM;
        t_n     = '0;
      end
      STREAM: begin
        if (int'(t) == LAST_T) begin
          state_n = (LANES > 1) ? FLUSH : FIN;
          t_n     = '0;
        end else begin
          t_n = t + TW'(1);
        end
      end
      FLUSH: begin
        if (int'(t) == LANES - 2) begin
          state_n = FIN;
          t_n     = '0;
        end else begin
          t_n = t + TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        t_n     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= state_n;
      t     <= t_n;
    end
  end

`ifdef FEEDER_ARR_CLR_EN
  // Registered from next state so the pulse lines up with the CLEAR cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) arr_clr <= 1'b0;
    else        arr_clr <= (state_n == CLEAR);
  end
`else
  assign arr_clr = 1'b0;
`endif

  // Lanes register the operand for the upcoming state/count, so the outputs
  // change on the same edge the FSM enters each stream step.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    feeder_lane #(.LANE(i), .DEPTH(DEPTH), .IW(IW), .TW(TW)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr_b    (wr_ok && !wr_sel && int'(wr_lane) == i),
      .wr_c    (wr_ok &&  wr_sel && int'(wr_lane) == i),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .rd_en   (state_n == STREAM),
      .rd_t    (t_n),
      .b_q     (b_q[i]),
      .c_q     (c_q[i])
    );
  end

  assign b_out = b_q;
  assign c_out = c_q;
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder (LANES=DEPTH=4). A scoreboard queue receives the
// full expected per-cycle output trace whenever a pass is started; a monitor
// pops and compares one entry per cycle. A table of point checks covers the
// landmark cycles of the first pass. Works with or without FEEDER_ARR_CLR_EN.
module tb_mac_operand_feeder;
  localparam int L = 4;
  localparam int D = 4;
`ifdef FEEDER_ARR_CLR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif
  localparam int PASS = CLR + (D + L - 1) + (L - 1) + 1;

  logic           clk = 1'b0, reset = 1'b0;
  logic           wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0;
  logic [1:0]     wr_lane = '0, wr_idx = '0;
  logic [7:0]     wr_data = '0;
  logic           busy, done, arr_clr;
  logic [8*L-1:0] b_out, c_out;

  mac_operand_feeder #(.LANES(L), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_lane(wr_lane),
    .wr_idx(wr_idx), .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .b_out(b_out), .c_out(c_out), .arr_clr(arr_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8*L-1:0] b;
    logic [8*L-1:0] c;
    logic           clr, bsy, dn;
    int             n;
  } exp_t;

  typedef struct {
    int n;     // pass cycle, counted with the CLEAR cycle present
    int kind;  // 0 b, 1 c, 2 arr_clr, 3 busy, 4 done
    int lane;
    int val;
  } pt_t;

  exp_t           sbq[$];
  exp_t           me;
  int             checks = 0, errors = 0;
  logic [7:0]     bm[L][D], cm[L][D];
  pt_t            tbl[16];
  logic [8*L-1:0] sb[0:15], sc[0:15];
  logic           scl[0:15], sbu[0:15], sdo[0:15];

  function automatic logic [7:0] ev(input bit sel, input int i, input int n);
    int t, k;
    t = n - 1 - CLR;
    k = t - i;
    if (t >= 0 && t <= D + L - 2 && k >= 0 && k < D) return sel ? cm[i][k] : bm[i][k];
    return 8'h00;
  endfunction

  task automatic push_pass(input int tail);
    exp_t e;
    for (int n = 1; n <= PASS + tail; n++) begin
      for (int i = 0; i < L; i++) begin
        e.b[8*i +: 8] = (n <= PASS) ? ev(1'b0, i, n) : 8'h00;
        e.c[8*i +: 8] = (n <= PASS) ? ev(1'b1, i, n) : 8'h00;
      end
      e.clr = (CLR == 1) && (n == 1);
      e.bsy = (n < PASS);
      e.dn  = (n == PASS);
      e.n   = n;
      sbq.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      checks++;
      if ({b_out, c_out, arr_clr, busy, done} !== {me.b, me.c, me.clr, me.bsy, me.dn}) begin
        errors++;
        $display("FAIL trace n=%0d act b=%h c=%h clr=%b busy=%b done=%b req b=%h c=%h clr=%b busy=%b done=%b",
                 me.n, b_out, c_out, arr_clr, busy, done, me.b, me.c, me.clr, me.bsy, me.dn);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge of pass cycle 1.
  task automatic start_pass(input int tail);
    start = 1'b1;
    push_pass(tail);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wr(input bit sel, input int lane, input int idx, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_lane = 2'(lane); wr_idx = 2'(idx); wr_data = d;
    if (sel) cm[lane][idx] = d; else bm[lane][idx] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic clr_model();
    for (int i = 0; i < L; i++)
      for (int k = 0; k < D; k++) begin bm[i][k] = 8'h00; cm[i][k] = 8'h00; end
  endtask

  initial begin
    int nn;
    logic [63:0] act;
    clr_model();
    tbl[0]  = '{1, 2, 0, CLR};
    tbl[1]  = '{1, 3, 0, 1};
    tbl[2]  = '{2, 0, 0, 8'h10};
    tbl[3]  = '{2, 1, 0, 8'h10};
    tbl[4]  = '{4, 0, 3, 8'h00};
    tbl[5]  = '{5, 0, 3, 8'h1C};
    tbl[6]  = '{5, 0, 1, 8'h16};
    tbl[7]  = '{8, 0, 3, 8'h1F};
    tbl[8]  = '{8, 0, 0, 8'h00};
    tbl[9]  = '{9, 0, 3, 8'h00};
    tbl[10] = '{11, 3, 0, 1};
    tbl[11] = '{11, 4, 0, 0};
    tbl[12] = '{12, 4, 0, 1};
    tbl[13] = '{12, 3, 0, 0};
    tbl[14] = '{13, 4, 0, 0};
    tbl[15] = '{2, 2, 0, 0};

    // Reset state
    #7;
    chk("rst_b_out", 64'(b_out), 64'h0);
    chk("rst_c_out", 64'(c_out), 64'h0);
    chk("rst_ctrl", 64'({busy, done, arr_clr}), 64'h0);
    @(negedge clk); reset = 1'b1;

    // Pattern 1: B[i][k] = C[i][k] = 8'h10 + 4i + k
    for (int i = 0; i < L; i++)
      for (int k = 0; k < D; k++) begin
        wr(1'b0, i, k, 8'(8'h10 + 4*i + k));
        wr(1'b1, i, k, 8'(8'h10 + 4*i + k));
      end

    // Full pass with landmark snapshots
    @(negedge clk);
    start = 1'b1;
    push_pass(1);
    @(posedge clk); #2;
    start = 1'b0;
    for (int n = 1; n <= PASS + 1; n++) begin
      sb[n] = b_out; sc[n] = c_out; scl[n] = arr_clr; sbu[n] = busy; sdo[n] = done;
      @(posedge clk); #2;
    end
    @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      nn = (tbl[j].n >= 2) ? tbl[j].n - 1 + CLR : tbl[j].n;
      case (tbl[j].kind)
        0: act = 64'(sb[nn][8*tbl[j].lane +: 8]);
        1: act = 64'(sc[nn][8*tbl[j].lane +: 8]);
        2: act = 64'(scl[nn]);
        3: act = 64'(sbu[nn]);
        default: act = 64'(sdo[nn]);
      endcase
      chk($sformatf("tbl%0d_n%0d_k%0d", j, nn, tbl[j].kind), act, 64'(tbl[j].val));
    end

    // Start pulse mid-pass is ignored: one done, trailing idle cycles
    @(negedge clk);
    start_pass(3);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (PASS + 3 - 6) @(negedge clk);

    // Write during busy is dropped; replay shows the old operand
    @(negedge clk);
    start_pass(3);
    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_sel = 1'b0; wr_lane = 2'd0; wr_idx = 2'd0; wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (PASS + 3 - 3) @(negedge clk);
    @(negedge clk);
    start_pass(3);
    repeat (PASS + 3) @(negedge clk);

    // Back-to-back: second start during the done cycle
    @(negedge clk);
    start_pass(0);
    repeat (PASS - 1) @(negedge clk);
    chk("b2b_done_seen", 64'(done), 64'h1);
    start_pass(3);
    repeat (PASS + 3) @(negedge clk);

    // Reset mid-pass
    @(negedge clk);
    start_pass(0);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    #1;
    chk("midrst_b_out", 64'(b_out), 64'h0);
    chk("midrst_c_out", 64'(c_out), 64'h0);
    chk("midrst_ctrl", 64'({busy, done, arr_clr}), 64'h0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("midrst_no_done", 64'({busy, done}), 64'h0);
    end
    reset = 1'b1;
    clr_model();
    @(negedge clk);
    start_pass(2);
    repeat (PASS + 2) @(negedge clk);

    // Pattern 2: distinct B/C contents, including a stored zero operand
    for (int i = 0; i < L; i++)
      for (int k = 0; k < D; k++) begin
        wr(1'b0, i, k, 8'(8'hA0 + 4*i + k));
        wr(1'b1, i, k, (i == 1 && k == 2) ? 8'h00 : 8'(8'h43 + 8*k + i));
      end
    @(negedge clk);
    start_pass(2);
    repeat (PASS + 2) @(negedge clk);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
